// File: rtl/pht_sat_table_pkg.sv
// Shared BPU definitions for the pattern-history table: default geometry,
// FSM state encoding and the saturating-counter step function.
package bpu_pkg;

    localparam int PHT_ENTRIES_DEF = 256;
    localparam int PHT_CNT_W_DEF   = 2;

    typedef enum logic {
        PHT_INIT = 1'b0,
        PHT_RUN  = 1'b1
    } pht_state_e;

    // One saturating step of a cnt_w-bit counter (cnt_w < 32).
    function automatic logic [31:0] sat_next(input logic [31:0] cnt,
                                             input logic        taken,
                                             input int unsigned cnt_w);
        logic [31:0] max_v;
        max_v = (32'd1 << cnt_w) - 32'd1;
        if (taken)
            return (cnt >= max_v) ? max_v : cnt + 32'd1;
        else
            return (cnt == 32'd0) ? 32'd0 : cnt - 32'd1;
    endfunction

endpackage

// File: rtl/pht_sat_table_if.sv
// Read/update bus of the pattern-history table; the table takes the slave
// modport, index generation / branch resolution drive the master side.
interface pht_sat_table_if #(
    parameter int ENTRIES  = 256,
    parameter int CNT_W    = 2,
    parameter int RD_PORTS = 2
);
    localparam int IDX_W = $clog2(ENTRIES);

    logic                      i_enable;
    logic                      i_flush;
    logic [RD_PORTS-1:0]       i_rd_vld;
    logic [RD_PORTS*IDX_W-1:0] i_rd_addr;
    logic [RD_PORTS*CNT_W-1:0] o_rd_cnt;
    logic [RD_PORTS-1:0]       o_rd_hit;
    logic                      i_upd_vld;
    logic [IDX_W-1:0]          i_upd_addr;
    logic                      i_upd_taken;
    logic                      o_ready;

    modport master (
        output i_enable, i_flush, i_rd_vld, i_rd_addr,
               i_upd_vld, i_upd_addr, i_upd_taken,
        input  o_rd_cnt, o_rd_hit, o_ready
    );

    modport slave (
        input  i_enable, i_flush, i_rd_vld, i_rd_addr,
               i_upd_vld, i_upd_addr, i_upd_taken,
        output o_rd_cnt, o_rd_hit, o_ready
    );
endinterface

// File: rtl/pht_sat_table_sat_next.sv
// Combinational saturating increment/decrement of one counter.
module pht_sat_next
    import bpu_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic [CNT_W-1:0] i_old,
    input  logic             i_taken,
    output logic [CNT_W-1:0] o_new
);
    assign o_new = CNT_W'(sat_next(32'(i_old), i_taken, CNT_W));
endmodule

// File: rtl/pht_sat_table.sv
// Multi-read-port PHT of saturating counters with a one-stage RMW update,
// write-first read bypass and a sequential init/flush sweep.
module pht_sat_table
    import bpu_pkg::*;
#(
    parameter int ENTRIES  = PHT_ENTRIES_DEF,
    parameter int CNT_W    = PHT_CNT_W_DEF,
    parameter int RD_PORTS = 2
) (
    input  logic           i_clk,
    input  logic           i_rst,
    pht_sat_table_if.slave bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CNT_W-1:0] WEAK_T  = CNT_W'(1) << (CNT_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic             valid;
        logic [CNT_W-1:0] cnt;
    } entry_t;

    entry_t           r_mem [ENTRIES];
    pht_state_e       r_state, w_state_next;
    logic [IDX_W-1:0] r_ptr, w_ptr_next;
    logic             r_u1_vld;
    logic [IDX_W-1:0] r_u1_addr;
    logic             r_u1_taken;

    logic             w_we;
    logic [IDX_W-1:0] w_waddr;
    entry_t           w_wdata;
    logic             w_accept;
    logic [CNT_W-1:0] w_old_cnt;
    logic [CNT_W-1:0] w_new_cnt;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= PHT_INIT;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
        end
    end

    // Next state: a flush in either state restarts the sweep from entry 0
    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        case (r_state)
            PHT_INIT: begin
                if (bus.i_flush) begin
                    w_ptr_next = '0;
                end else begin
                    w_ptr_next = r_ptr + 1'b1;
                    if (r_ptr == IDX_W'(ENTRIES - 1))
                        w_state_next = PHT_RUN;
                end
            end
            PHT_RUN: begin
                if (bus.i_flush) begin
                    w_state_next = PHT_INIT;
                    w_ptr_next   = '0;
                end
            end
            default: w_state_next = PHT_INIT;
        endcase
    end

    // Outputs: single array write port shared by the sweep and U1 commit
    always_comb begin
        bus.o_ready = 1'b0;
        w_we        = 1'b0;
        w_waddr     = r_ptr;
        w_wdata     = '{valid: 1'b0, cnt: WEAK_T};
        case (r_state)
            PHT_INIT: w_we = 1'b1;
            PHT_RUN: begin
                bus.o_ready = 1'b1;
                w_we        = r_u1_vld;
                w_waddr     = r_u1_addr;
                w_wdata     = '{valid: 1'b1, cnt: w_new_cnt};
            end
            default: ;
        endcase
    end

    assign w_accept = bus.i_upd_vld & bus.i_enable & bus.o_ready & ~bus.i_flush;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_u1_vld   <= 1'b0;
            r_u1_addr  <= '0;
            r_u1_taken <= 1'b0;
        end else begin
            r_u1_vld <= w_accept;
            if (w_accept) begin
                r_u1_addr  <= bus.i_upd_addr;
                r_u1_taken <= bus.i_upd_taken;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_we)
            r_mem[w_waddr] <= w_wdata;
    end

    assign w_old_cnt = r_mem[r_u1_addr].cnt;

    // One step function feeds both the commit write and the read bypass
    pht_sat_next #(.CNT_W(CNT_W)) u_sat_next (
        .i_old   (w_old_cnt),
        .i_taken (r_u1_taken),
        .o_new   (w_new_cnt)
    );

    generate
        for (genvar gi = 0; gi < RD_PORTS; gi++) begin : g_rd
            logic [IDX_W-1:0] w_addr;
            entry_t           w_ent;
            assign w_addr = bus.i_rd_addr[gi*IDX_W +: IDX_W];
            assign w_ent  = r_mem[w_addr];

            always_comb begin
                bus.o_rd_cnt[gi*CNT_W +: CNT_W] = WEAK_T;
                bus.o_rd_hit[gi]                = 1'b0;
                if (bus.i_rd_vld[gi] && r_state == PHT_RUN) begin
                    if (r_u1_vld && r_u1_addr == w_addr) begin
                        bus.o_rd_cnt[gi*CNT_W +: CNT_W] = w_new_cnt;
                        bus.o_rd_hit[gi]                = 1'b1;
                    end else begin
                        bus.o_rd_cnt[gi*CNT_W +: CNT_W] = w_ent.cnt;
                        bus.o_rd_hit[gi]                = w_ent.valid;
                    end
                end
            end

            a_bypass: assert property (@(posedge i_clk) disable iff (i_rst)
                (r_u1_vld && bus.i_rd_vld[gi] && r_u1_addr == w_addr)
                |-> (bus.o_rd_cnt[gi*CNT_W +: CNT_W] == w_new_cnt && bus.o_rd_hit[gi]));
        end
    endgenerate

    a_ready_init: assert property (@(posedge i_clk) disable iff (i_rst)
        !(r_state == PHT_INIT && bus.o_ready));

    a_sat_hi: assert property (@(posedge i_clk) disable iff (i_rst)
        (r_u1_vld && r_u1_taken && w_old_cnt == CNT_MAX) |-> (w_new_cnt == CNT_MAX));

    a_sat_lo: assert property (@(posedge i_clk) disable iff (i_rst)
        (r_u1_vld && !r_u1_taken && w_old_cnt == '0) |-> (w_new_cnt == '0));

endmodule

// File: tb/tb_pht_sat_table.sv
// Directed bench for pht_sat_table (16 entries, 2-bit counters, 2 read ports).
module tb_pht_sat_table;
    localparam int ENTRIES  = 16;
    localparam int CNT_W    = 2;
    localparam int RD_PORTS = 2;
    localparam int IDX_W    = 4;

    logic clk;
    logic srst;
    int   n_checks;
    int   n_fail;

    pht_sat_table_if #(.ENTRIES(ENTRIES), .CNT_W(CNT_W), .RD_PORTS(RD_PORTS)) bus ();

    pht_sat_table #(.ENTRIES(ENTRIES), .CNT_W(CNT_W), .RD_PORTS(RD_PORTS)) dut (
        .i_clk (clk),
        .i_rst (srst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end else begin
            $display("ok   %s got=%0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int p, input logic vld, input int addr);
        bus.i_rd_vld[p]                  = vld;
        bus.i_rd_addr[p*IDX_W +: IDX_W] = IDX_W'(addr);
    endtask

    // Read port p at addr, settle, compare count and hit
    task automatic rd_chk(input string tag, input int p, input int addr,
                          input int exp_cnt, input int exp_hit);
        set_rd(p, 1'b1, addr);
        #1;
        check({tag, "_cnt"}, int'(bus.o_rd_cnt[p*CNT_W +: CNT_W]), exp_cnt);
        check({tag, "_hit"}, int'(bus.o_rd_hit[p]), exp_hit);
    endtask

    task automatic drive_upd(input logic vld, input int addr, input logic taken);
        bus.i_upd_vld   = vld;
        bus.i_upd_addr  = IDX_W'(addr);
        bus.i_upd_taken = taken;
    endtask

    // Accept an update at the next edge, then stop requesting
    task automatic upd(input int addr, input logic taken);
        drive_upd(1'b1, addr, taken);
        tick();
        drive_upd(1'b0, 0, 1'b0);
    endtask

    initial begin
        int sat_exp [7];
        n_checks = 0;
        n_fail   = 0;
        srst            = 1'b1;
        bus.i_enable    = 1'b1;
        bus.i_flush     = 1'b0;
        bus.i_rd_vld    = '0;
        bus.i_rd_addr   = '0;
        drive_upd(1'b0, 0, 1'b0);
        tick();
        tick();
        check("rst_ready", int'(bus.o_ready), 0);
        rd_chk("rst_rd0", 0, 0, 2, 0);
        rd_chk("rst_rd1", 1, 9, 2, 0);
        srst = 1'b0;

        // Init sweep: 16 cycles not ready, ready on the 17th
        for (int i = 0; i < ENTRIES; i++) begin
            check($sformatf("init_ready_c%0d", i), int'(bus.o_ready), 0);
            if (i % 5 == 0) rd_chk($sformatf("init_rd_c%0d", i), 0, i, 2, 0);
            tick();
        end
        check("run_ready", int'(bus.o_ready), 1);
        rd_chk("run_fresh", 0, 0, 2, 0);

        // Saturation at addr 5
        sat_exp = '{3, 3, 3, 2, 1, 0, 0};
        for (int k = 0; k < 7; k++) begin
            upd(5, (k < 3) ? 1'b1 : 1'b0);
            tick();
            rd_chk($sformatf("sat_%0d", k), 0, 5, sat_exp[k], 1);
        end
        set_rd(1, 1'b0, 5);
        #1;
        check("rd_novld_cnt", int'(bus.o_rd_cnt[CNT_W +: CNT_W]), 2);
        check("rd_novld_hit", int'(bus.o_rd_hit[1]), 0);

        // Bypass: invisible at accept, bypassed in U1 cycle, then from array
        drive_upd(1'b1, 7, 1'b1);
        rd_chk("byp_accept", 0, 7, 2, 0);
        tick();
        drive_upd(1'b0, 0, 1'b0);
        rd_chk("byp_u1_p0", 0, 7, 3, 1);
        rd_chk("byp_u1_p1", 1, 8, 2, 0);
        tick();
        rd_chk("byp_array", 0, 7, 3, 1);

        // Back-to-back updates to addr 3: T, T, NT
        drive_upd(1'b1, 3, 1'b1);
        rd_chk("b2b_a", 0, 3, 2, 0);
        tick();
        drive_upd(1'b1, 3, 1'b1);
        rd_chk("b2b_b", 0, 3, 3, 1);
        tick();
        drive_upd(1'b1, 3, 1'b0);
        rd_chk("b2b_c", 0, 3, 3, 1);
        tick();
        drive_upd(1'b0, 0, 1'b0);
        rd_chk("b2b_d", 0, 3, 2, 1);
        tick();
        rd_chk("b2b_final", 0, 3, 2, 1);

        // Disabled update is dropped
        bus.i_enable = 1'b0;
        upd(9, 1'b1);
        bus.i_enable = 1'b1;
        tick();
        rd_chk("en0_drop", 0, 9, 2, 0);

        // Flush in RUN: update in the flush cycle is dropped
        upd(1, 1'b1);
        tick();
        rd_chk("pre_flush", 0, 1, 3, 1);
        bus.i_flush = 1'b1;
        drive_upd(1'b1, 2, 1'b1);
        tick();
        bus.i_flush = 1'b0;
        drive_upd(1'b1, 4, 1'b1);    // o_ready low: must be dropped too
        check("flush_ready", int'(bus.o_ready), 0);
        tick();
        drive_upd(1'b0, 0, 1'b0);
        for (int i = 1; i < 5; i++) begin
            check($sformatf("flush_ready_c%0d", i), int'(bus.o_ready), 0);
            tick();
        end
        // Second flush mid-sweep restarts a full 16-cycle sweep
        bus.i_flush = 1'b1;
        tick();
        bus.i_flush = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            check($sformatf("reflush_ready_c%0d", i), int'(bus.o_ready), 0);
            tick();
        end
        check("reflush_run", int'(bus.o_ready), 1);
        rd_chk("post_flush_a1", 0, 1, 2, 0);
        rd_chk("post_flush_a2", 1, 2, 2, 0);
        tick();
        rd_chk("post_flush_a4", 0, 4, 2, 0);
        rd_chk("post_flush_a5", 1, 5, 2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pht_sat_table.md
Name: pht_sat_table

Overview:
Parametrised pattern-history table of saturating counters for the branch predictor. It is the successor to the single-port 2-bit micro-PHT. It adds the following over that block:
- multiple combinational read ports
- configurable depth and counter width
- internal read-modify-write saturating update from a taken/not-taken outcome
- write-first read bypass
- a sequential init/flush sweep

It sits in the BPU between index generation and the direction-prediction mux.

Parameters:
ENTRIES, 256, number of table entries (power of two, >=4)
CNT_W, 2, saturating counter width (>=1)
RD_PORTS, 2, number of independent read ports
IDX_W, $clog2(ENTRIES), index width (derived, not overridden)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_enable  in  1  update gate; update accepted only when high
i_flush  in  1  start re-initialisation sweep
i_rd_vld  in  RD_PORTS  per-port read valid
i_rd_addr  in  RD_PORTS*IDX_W  per-port index, port p at [p*IDX_W +: IDX_W]
o_rd_cnt  out  RD_PORTS*CNT_W  per-port counter value
o_rd_hit  out  RD_PORTS  per-port entry-valid flag
i_upd_vld  in  1  update request
i_upd_addr  in  IDX_W  update index
i_upd_taken  in  1  resolved direction: 1 = increment, 0 = decrement
o_ready  out  1  table initialised and accepting updates

Behaviour:
- Constants: WEAK_T = 1<<(CNT_W-1); CNT_MAX = all ones.
- Entry format: {valid, cnt[CNT_W-1:0]}.
- FSM has two states, INIT and RUN.
- i_rst (sampled at posedge i_clk) -> state INIT, sweep ptr=0, U1 stage invalid, o_ready=0.
- Reset mid-operation behaves identically to reset; any pending update is lost.
- INIT:
  - Each cycle writes entry[ptr] = {0, WEAK_T}, then ptr++.
  - When ptr==ENTRIES-1 is written, next state is RUN.
  - Sweep lasts exactly ENTRIES cycles; o_ready=1 on the first RUN cycle.
  - Array contents are not reset directly; only the sweep initialises them.
- RUN + i_flush -> INIT with ptr=0; the U1 stage is invalidated on that same edge.
- i_flush during INIT restarts the sweep at ptr=0.
- i_rst has priority over i_flush.
- Update acceptance: at an edge where i_upd_vld & i_enable & o_ready & ~i_flush, the U1 register captures {addr, taken}.
- Requests failing that condition are dropped silently; there is no backpressure beyond o_ready.
- U1 commit, in the cycle after acceptance:
  - old = array[U1.addr]
  - new.cnt = taken ? (old==CNT_MAX ? CNT_MAX : old+1) : (old==0 ? 0 : old-1)
  - new.valid = 1
  - Written at the next edge regardless of i_enable.
- Back-to-back updates to the same address need no forwarding, because the array is already written when the second request reaches U1.
- Update throughput: 1/cycle.
- Read ports are combinational (0-cycle latency) and independent; any ports may alias.
- Read port p output:
  - i_rd_vld[p]=0 or state INIT -> cnt=WEAK_T, hit=0.
  - U1 valid and U1.addr==rd_addr[p] -> the new value being committed this cycle (write-first bypass).
  - Otherwise -> array entry.
- Visibility of an update: invisible in its accept cycle; visible via bypass in the U1 cycle; visible from the array afterwards.
- Output reset values: o_ready=0, o_rd_hit=0, o_rd_cnt=WEAK_T on all ports.
- Index width: addresses are IDX_W wide, so no out-of-range case exists; ptr wraps only through a state change.
- Assertions:
  - o_ready is never high in INIT.
  - An update followed by a read of the same addr in the following cycle returns the saturated new value.
  - cnt never leaves [0, CNT_MAX].

Decomposition:
- bpu_pkg holds:
  - PHT_ENTRIES_DEF and PHT_CNT_W_DEF constants
  - pht_state_e enum {PHT_INIT, PHT_RUN}
  - a function sat_next(cnt, taken, cnt_w) used by RTL and the scoreboard
- The entry struct is declared locally because it is width-parametrised.
- One combinational sub-module, pht_sat_next (CNT_W param: old, taken -> new), shared by the commit path and the bypass path.

Test Plan:
- Reset, ENTRIES=16, CNT_W=2: o_ready low 16 cycles, high on cycle 17; reads meanwhile give cnt=2'b10, hit=0.
- Saturation at addr 5: three taken updates -> reads 3,3,3 after each commit; then four not-taken -> 2,1,0,0; hit=1 throughout.
- Bypass: update addr 7 taken (old 2) at edge N; port0 reads addr 7 in cycle N..N+1 -> 3 (bypass); port1 reads addr 8 in the same cycle -> 2.
- Back-to-back same address: updates to addr 3 taken/taken/not-taken on consecutive cycles -> final array value 2, intermediate reads 3,3,2.
- Update with i_enable=0, or while o_ready=0: no change, entry still 2, hit=0.
- i_flush in RUN after writing addr 1=3: update issued in the flush cycle is dropped, o_ready low for 16 cycles, addr 1 reads 2 with hit=0 afterwards; a second flush mid-sweep extends INIT to 16 cycles from that point.
